// File: rtl/vga_fb_scanout_if.sv
// Framebuffer pixel read port between the CPU framebuffer and the VGA scanout.
// The scanout is the master: it presents an address and takes the RGB332 byte back.
interface vga_fb_scanout_if;
  logic [31:0] vga_pixel_addr;
  logic [7:0]  vga_pixel_val;

  modport master (output vga_pixel_addr, input vga_pixel_val);
  modport slave  (input vga_pixel_addr, output vga_pixel_val);
endinterface

// File: rtl/vga_fb_scanout.sv
// VGA scanout: generates raster timing, walks a low-resolution framebuffer in
// raster order (each fb pixel replicated SCALE x SCALE on screen) and expands
// RGB332 bytes to 8/8/8 for the DAC.
// Pipeline: S0 counters -> S1 address + flags -> S2 output registers.
// All outputs lag their S0 counter position by exactly two clocks.
module vga_fb_scanout #(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter int          FB_W      = 160,
  parameter int          FB_H      = 120,
  parameter int          SCALE     = 4,
  parameter logic [31:0] ADDR_BASE = 32'd0,
  parameter logic [7:0]  BORDER    = 8'h00,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  vga_fb_scanout_if.master          pix,
  output logic [7:0]                vga_r,
  output logic [7:0]                vga_g,
  output logic [7:0]                vga_b,
  output logic                      vga_hsync,
  output logic                      vga_vsync,
  output logic                      vga_blank_n,
  output logic                      vga_sync_n,
  output logic                      frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_HS0  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_HS1  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_WIN  = HW'(FB_W * SCALE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_VS0  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_VS1  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_WIN  = VW'(FB_H * SCALE);
  localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);

  // S0 state
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [SW-1:0] sx;
  logic [SW-1:0] sy;
  logic [31:0]   col;
  logic [31:0]   line_base;

  // S0 decoded flags
  logic line_end, frame_end;
  logic vis0, win0, hs0, vs0, first0;

  // S1 state
  logic [31:0] addr;
  logic        vis1, win1, hs1, vs1, first1;

  // S2 colour source and expansion
  logic [7:0]  px;

  assign line_end  = (hcnt == H_LAST);
  assign frame_end = line_end && (vcnt == V_LAST);
  assign vis0      = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign win0      = (hcnt < H_WIN) && (vcnt < V_WIN);
  assign hs0       = (hcnt >= H_HS0) && (hcnt < H_HS1);
  assign vs0       = (vcnt >= V_VS0) && (vcnt < V_VS1);
  assign first0    = (hcnt == '0) && (vcnt == '0);

  // Raster counters: hcnt every clock, vcnt on each line wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  // Horizontal fb column: sx divides the pixel clock by SCALE, no divider needed
  always_ff @(posedge clk) begin
    if (reset || line_end) begin
      sx  <= '0;
      col <= '0;
    end else if (sx == S_LAST) begin
      sx  <= '0;
      col <= col + 32'd1;
    end else begin
      sx  <= sx + SW'(1);
    end
  end

  // Vertical fb row base: sy counts visible lines, line_base steps one fb row per SCALE lines
  always_ff @(posedge clk) begin
    if (reset || frame_end) begin
      sy        <= '0;
      line_base <= '0;
    end else if (line_end && (vcnt < V_VIS)) begin
      if (sy == S_LAST) begin
        sy        <= '0;
        line_base <= line_base + 32'(FB_W);
      end else begin
        sy        <= sy + SW'(1);
      end
    end
  end

  // S1: issue the framebuffer address (held outside the window) and delay the flags
  always_ff @(posedge clk) begin
    if (reset) begin
      addr   <= ADDR_BASE;
      vis1   <= 1'b0;
      win1   <= 1'b0;
      hs1    <= 1'b0;
      vs1    <= 1'b0;
      first1 <= 1'b0;
    end else begin
      if (win0) begin
        addr <= ADDR_BASE + line_base + col;
      end
      vis1   <= vis0;
      win1   <= win0;
      hs1    <= hs0;
      vs1    <= vs0;
      first1 <= first0;
    end
  end

  assign pix.vga_pixel_addr = addr;
  assign px = win1 ? pix.vga_pixel_val : BORDER;

  // S2: expand RGB332 to 8/8/8 and register sync/blank alongside the colour
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
      vga_hsync   <= ~SYNC_POL;
      vga_vsync   <= ~SYNC_POL;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (vis1) begin
        vga_r <= {px[7:5], px[7:5], px[7:6]};
        vga_g <= {px[4:2], px[4:2], px[4:3]};
        vga_b <= {px[1:0], px[1:0], px[1:0], px[1:0]};
      end else begin
        vga_r <= 8'h00;
        vga_g <= 8'h00;
        vga_b <= 8'h00;
      end
      vga_hsync   <= hs1 ? SYNC_POL : ~SYNC_POL;
      vga_vsync   <= vs1 ? SYNC_POL : ~SYNC_POL;
      vga_blank_n <= vis1;
      frame_start <= first1;
    end
  end

  // No sync-on-green
  assign vga_sync_n = 1'b0;
endmodule
